seq_onehot_decoder: RTL and testbench

//  Registered, handshaked N-to-NOUT one-hot select generator; successor to the fixed 2-to-4 enable decoder.

---
 rtl/seq_dec_pkg.sv | 21 ++
 rtl/onehot_dec.sv | 19 +
 rtl/seq_onehot_decoder.sv | 141 ++++++++++++++
 tb/tb_seq_onehot_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_dec_pkg.sv
// Shared types and helpers for the sequenced one-hot select generator.
package seq_dec_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } seq_dec_state_t;

  localparam int unsigned SEQ_DEC_MAX_NOUT = 64;

  // One-hot of addr over nout lines; all-zero when addr is out of range.
  function automatic logic [SEQ_DEC_MAX_NOUT-1:0] onehot(input int unsigned addr,
                                                         input int unsigned nout);
    logic [SEQ_DEC_MAX_NOUT-1:0] v;
    v = '0;
    if ((addr < nout) && (addr < SEQ_DEC_MAX_NOUT)) v = 64'd1 << addr;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational address to one-hot decoder with an in-range flag.
module onehot_dec
  import seq_dec_pkg::*;
#(
  parameter int unsigned AW   = 2,
  parameter int unsigned NOUT = 4
) (
  input  logic [AW-1:0]   i_addr,
  output logic [NOUT-1:0] o_sel,
  output logic            o_in_range
);

  logic [SEQ_DEC_MAX_NOUT-1:0] w_full;

  assign w_full     = onehot(32'(i_addr), NOUT);
  assign o_sel      = w_full[NOUT-1:0];
  assign o_in_range = |w_full;

endmodule

// File: rtl/seq_onehot_decoder.sv
// Handshaked one-hot select generator: drive one line for len cycles, then a gap.
// Optional feature macro: SEQ_DEC_ERR_EN (out-of-range addr flagged on err instead of driving).
module seq_onehot_decoder
  import seq_dec_pkg::*;
#(
  parameter int unsigned AW         = 2,
  parameter int unsigned NOUT       = 4,
  parameter int unsigned LW         = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [LW-1:0]   req_len,
  output logic [NOUT-1:0] sel,
  output logic            sel_oe,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_dec_state_t  r_state, w_state_nxt;
  logic [LW-1:0]   r_cnt, w_cnt_nxt, w_cnt_load;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [NOUT-1:0] r_sel, w_sel_nxt, w_dec_sel, w_sel_load;
  logic            r_sel_oe, w_oe_nxt;
  logic            r_busy, r_done, w_done_nxt, r_err, w_err_nxt;
  logic            w_in_range, w_accept;

  onehot_dec #(.AW(AW), .NOUT(NOUT)) u_dec (
    .i_addr     (req_addr),
    .o_sel      (w_dec_sel),
    .o_in_range (w_in_range)
  );

  assign req_ready  = (r_state == S_IDLE) & en & ~rst;
  assign w_accept   = req_valid & req_ready;
  assign w_cnt_load = (req_len == '0) ? '0 : req_len - LW'(1);
  assign w_sel_load = w_in_range ? w_dec_sel : '0;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_sel_nxt   = r_sel;
    w_oe_nxt    = r_sel_oe;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        w_oe_nxt  = 1'b0;
        if (w_accept) begin
`ifdef SEQ_DEC_ERR_EN
          if (!w_in_range) begin
            w_err_nxt = 1'b1;
          end else begin
`else
          begin
`endif
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = w_cnt_load;
            w_sel_nxt   = w_sel_load;
            w_oe_nxt    = 1'b1;
            w_done_nxt  = (w_cnt_load == '0);
          end
        end
      end
      S_DRIVE: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
          w_oe_nxt    = 1'b0;
        end else if (r_cnt == '0) begin
          w_sel_nxt = '0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GW'(GAP_CYCLES - 1);
            w_oe_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
          end
        end else begin
          w_cnt_nxt  = r_cnt - LW'(1);
          w_done_nxt = (r_cnt == LW'(1));
        end
      end
      S_GAP: begin
        w_sel_nxt = '0;
        if (!en || (r_gap == '0)) begin
          w_state_nxt = S_IDLE;
          w_oe_nxt    = 1'b0;
        end else begin
          w_gap_nxt = r_gap - GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
        w_oe_nxt    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_sel    <= '0;
      r_sel_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_sel    <= w_sel_nxt;
      r_sel_oe <= w_oe_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign sel    = r_sel;
  assign sel_oe = r_sel_oe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed bench for seq_onehot_decoder: default, zero-gap and NOUT=3 instances share inputs.
module tb_seq_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [3:0] req_len = 4'd0;

  logic       rdy0, oe0, busy0, done0, err0;
  logic [3:0] sel0;
  logic       rdy1, oe1, busy1, done1, err1;
  logic [3:0] sel1;
  logic       rdy2, oe2, busy2, done2, err2;
  logic [2:0] sel2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seq_onehot_decoder #(.AW(2), .NOUT(4), .LW(4), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(req_addr), .req_len(req_len), .sel(sel0), .sel_oe(oe0),
    .busy(busy0), .done(done0), .err(err0));

  seq_onehot_decoder #(.AW(2), .NOUT(4), .LW(4), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(req_addr), .req_len(req_len), .sel(sel1), .sel_oe(oe1),
    .busy(busy1), .done(done1), .err(err1));

  seq_onehot_decoder #(.AW(2), .NOUT(3), .LW(4), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(rdy2),
    .req_addr(req_addr), .req_len(req_len), .sel(sel2), .sel_oe(oe2),
    .busy(busy2), .done(done2), .err(err2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int cycles;
    logic seen;

    // Reset values
    do_reset();
    check_eq("rst_sel", 32'(sel0), 32'h0);
    check_eq("rst_oe", 32'(oe0), 32'h0);
    check_eq("rst_busy", 32'(busy0), 32'h0);
    check_eq("rst_done", 32'(done0), 32'h0);
    check_eq("rst_err", 32'(err0), 32'h0);
    check_eq("rst_ready", 32'(rdy0), 32'h1);

    // Reset in the middle of DRIVE
    req_valid = 1'b1; req_addr = 2'd2; req_len = 4'd5;
    tick();
    req_valid = 1'b0;
    check_eq("mid_drive_sel", 32'(sel0), 32'h4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_sel", 32'(sel0), 32'h0);
    check_eq("midrst_oe", 32'(oe0), 32'h0);
    check_eq("midrst_busy", 32'(busy0), 32'h0);
    check_eq("midrst_ready", 32'(rdy0), 32'h1);

    // addr=2 len=3 with one gap cycle; addr/len changes after accept are ignored
    do_reset();
    req_valid = 1'b1; req_addr = 2'd2; req_len = 4'd3;
    tick();
    req_valid = 1'b0; req_addr = 2'd0; req_len = 4'd9;
    check_eq("t1_sel", 32'(sel0), 32'h4);
    check_eq("t1_oe", 32'(oe0), 32'h1);
    check_eq("t1_done", 32'(done0), 32'h0);
    check_eq("t1_busy", 32'(busy0), 32'h1);
    tick();
    check_eq("t2_sel", 32'(sel0), 32'h4);
    check_eq("t2_done", 32'(done0), 32'h0);
    tick();
    check_eq("t3_sel", 32'(sel0), 32'h4);
    check_eq("t3_done", 32'(done0), 32'h1);
    req_valid = 1'b1;
    tick();
    check_eq("gap_sel", 32'(sel0), 32'h0);
    check_eq("gap_oe", 32'(oe0), 32'h1);
    check_eq("gap_done", 32'(done0), 32'h0);
    check_eq("gap_ready", 32'(rdy0), 32'h0);
    req_valid = 1'b0;
    tick();
    check_eq("t5_oe", 32'(oe0), 32'h0);
    check_eq("t5_busy", 32'(busy0), 32'h0);
    check_eq("t5_ready", 32'(rdy0), 32'h1);

    // len=0 treated as a single drive cycle
    do_reset();
    req_valid = 1'b1; req_addr = 2'd1; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    check_eq("len0_sel", 32'(sel0), 32'h2);
    check_eq("len0_done", 32'(done0), 32'h1);
    tick();
    check_eq("len0_gap_sel", 32'(sel0), 32'h0);
    check_eq("len0_gap_done", 32'(done0), 32'h0);
    check_eq("len0_gap_oe", 32'(oe0), 32'h1);

    // Zero-gap back-to-back with valid held
    do_reset();
    req_valid = 1'b1; req_addr = 2'd0; req_len = 4'd2;
    tick();
    req_addr = 2'd3;
    check_eq("b2b_c1", 32'(sel1), 32'h1);
    tick();
    check_eq("b2b_c2", 32'(sel1), 32'h1);
    check_eq("b2b_done", 32'(done1), 32'h1);
    tick();
    check_eq("b2b_c3", 32'(sel1), 32'h0);
    check_eq("b2b_c3_ready", 32'(rdy1), 32'h1);
    tick();
    check_eq("b2b_c4", 32'(sel1), 32'h8);
    tick();
    req_valid = 1'b0;
    check_eq("b2b_c5", 32'(sel1), 32'h8);

    // en dropped on the 2nd DRIVE cycle of len=4
    do_reset();
    req_valid = 1'b1; req_addr = 2'd1; req_len = 4'd4;
    tick();
    req_valid = 1'b0;
    tick();
    check_eq("en_pre_sel", 32'(sel0), 32'h2);
    en = 1'b0;
    req_valid = 1'b1; req_addr = 2'd0;
    tick();
    check_eq("en_abort_sel", 32'(sel0), 32'h0);
    check_eq("en_abort_oe", 32'(oe0), 32'h0);
    check_eq("en_abort_done", 32'(done0), 32'h0);
    check_eq("en_abort_ready", 32'(rdy0), 32'h0);
    tick();
    check_eq("en_hold_busy", 32'(busy0), 32'h0);
    check_eq("en_hold_done", 32'(done0), 32'h0);
    req_valid = 1'b0;
    en = 1'b1;
    #1;
    check_eq("en_back_ready", 32'(rdy0), 32'h1);

    // Maximum length runs the full 15 cycles without wrapping
    do_reset();
    req_valid = 1'b1; req_addr = 2'd3; req_len = 4'd15;
    tick();
    req_valid = 1'b0;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sel0 == 4'b1000) cycles++;
      if (done0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq("maxlen_done_seen", 32'(seen), 32'h1);
    check_eq("maxlen_cycles", 32'(cycles), 32'd15);

    // NOUT=3: in-range then out-of-range address
    do_reset();
    req_valid = 1'b1; req_addr = 2'd2; req_len = 4'd1;
    tick();
    req_valid = 1'b0;
    check_eq("n3_inrange_sel", 32'(sel2), 32'h4);
    check_eq("n3_inrange_done", 32'(done2), 32'h1);
    do_reset();
    req_valid = 1'b1; req_addr = 2'd3; req_len = 4'd2;
    tick();
    req_valid = 1'b0;
`ifdef SEQ_DEC_ERR_EN
    check_eq("oor_err", 32'(err2), 32'h1);
    check_eq("oor_sel", 32'(sel2), 32'h0);
    check_eq("oor_oe", 32'(oe2), 32'h0);
    check_eq("oor_busy", 32'(busy2), 32'h0);
    check_eq("oor_ready", 32'(rdy2), 32'h1);
    tick();
    check_eq("oor_err_pulse", 32'(err2), 32'h0);
    check_eq("oor_done", 32'(done2), 32'h0);
`else
    check_eq("oor_c1_sel", 32'(sel2), 32'h0);
    check_eq("oor_c1_oe", 32'(oe2), 32'h1);
    check_eq("oor_c1_done", 32'(done2), 32'h0);
    tick();
    check_eq("oor_c2_sel", 32'(sel2), 32'h0);
    check_eq("oor_c2_done", 32'(done2), 32'h1);
    check_eq("oor_err", 32'(err2), 32'h0);
    tick();
    check_eq("oor_gap_oe", 32'(oe2), 32'h1);
    tick();
    check_eq("oor_idle_busy", 32'(busy2), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
